// File: rtl/spi_master_ss.sv
// SPI master with slave-select generation; mode, width and timing fixed by parameters.
// Optional receive path is built only when SPI_MASTER_SS_READ_EN is defined.
module spi_master_ss #(
    parameter int unsigned WID             = 24,
    parameter int unsigned POLARITY        = 0,
    parameter int unsigned PHASE           = 0,
    parameter int unsigned CYCLE_HALF_WAIT = 1,
    parameter int unsigned SS_WAIT         = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arm,
    input  logic [WID-1:0] to_slave,
    output logic [WID-1:0] from_slave,
    output logic           ready_to_arm,
    output logic           finished,
    output logic           mosi,
    input  logic           miso,
    output logic           sck,
    output logic           ss_L
);

    localparam int unsigned HW = $clog2(CYCLE_HALF_WAIT + 1) + 1;
    localparam int unsigned SW = $clog2(SS_WAIT + 1) + 1;
    localparam int unsigned EW = $clog2(2 * WID) + 1;

    localparam logic          SCK_IDLE   = (POLARITY != 0);
    localparam logic          CPHA0      = (PHASE == 0);
    localparam logic [HW-1:0] HALF_LAST  = HW'(CYCLE_HALF_WAIT);
    localparam logic [SW-1:0] HOLD_LAST  = SW'(SS_WAIT);
    localparam logic [SW-1:0] SETUP_LAST = (SS_WAIT == 0) ? '0 : SW'(SS_WAIT - 1);
    localparam logic [EW-1:0] EDGE_LAST  = EW'(2 * WID - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [HW-1:0]  half_q, half_d;
    logic [EW-1:0]  edge_q, edge_d;
    logic [WID-1:0] tx_q, tx_d;
    logic           sck_q, sck_d;
    logic           ss_q, ss_d;
    logic           mosi_q, mosi_d;
    logic           fin_q, fin_d;
    logic           sample;
    logic           leading;

    // Even edge count means the next toggle leaves the idle level.
    assign leading = ~edge_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        sck_d   = sck_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        fin_d   = fin_q;
        sample  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    tx_d    = to_slave;
                    ss_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StSetup;
                    if (CPHA0) mosi_d = to_slave[WID-1];
                end
            end
            StSetup: begin
                if (cnt_q >= SETUP_LAST) begin
                    half_d  = '0;
                    edge_d  = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 1'b1;
                    if (leading == CPHA0) begin
                        sample = 1'b1;
                    end else if (CPHA0) begin
                        // The final trailing edge follows the last sample; leave mosi alone.
                        if (edge_q != EDGE_LAST) begin
                            mosi_d = tx_q[WID-2];
                            tx_d   = tx_q << 1;
                        end
                    end else begin
                        mosi_d = tx_q[WID-1];
                        tx_d   = tx_q << 1;
                    end
                    if (edge_q == EDGE_LAST) begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == HOLD_LAST) begin
                    ss_d    = 1'b1;
                    fin_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (!arm) begin
                    fin_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            half_q  <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            sck_q   <= SCK_IDLE;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            sck_q   <= sck_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            fin_q   <= fin_d;
        end
    end

`ifdef SPI_MASTER_SS_READ_EN
    logic [WID-1:0] rx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q <= '0;
        end else if (sample) begin
            rx_q <= {rx_q[WID-2:0], miso};
        end
    end

    assign from_slave = rx_q;
`else
    logic unused_rx;
    assign unused_rx  = miso ^ sample;
    assign from_slave = '0;
`endif

    assign ready_to_arm = (state_q == StIdle);
    assign finished     = fin_q;
    assign mosi         = mosi_q;
    assign sck          = sck_q;
    assign ss_L         = ss_q;

endmodule

// File: tb/tb_spi_master_ss.sv
// Directed bench: four spi_master_ss instances (modes 0-3) driven in lockstep,
// each talking to a simple SPI slave model.
module tb_spi_master_ss;

    localparam int unsigned W = 8;
`ifdef SPI_MASTER_SS_READ_EN
    localparam bit RD = 1'b1;
`else
    localparam bit RD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         arm = 1'b0;
    logic [W-1:0] to_slave = '0;
    logic [W-1:0] sw = '0;

    logic [W-1:0] from_slave [4];
    logic [W-1:0] rcv_all    [4];
    logic         ready      [4];
    logic         fin        [4];
    logic         mosi       [4];
    logic         sck        [4];
    logic         ss_l       [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        localparam int unsigned CPOL = g / 2;
        localparam int unsigned CPHA = g % 2;
        localparam int          OFS  = (CPHA == 0) ? 1 : 0;

        logic         miso_s = 1'b0;
        logic         sck_p  = 1'b0;
        logic         ss_p   = 1'b1;
        logic [W-1:0] rcv    = '0;
        int           idx    = 0;

        spi_master_ss #(
            .WID            (W),
            .POLARITY       (CPOL),
            .PHASE          (CPHA),
            .CYCLE_HALF_WAIT(1),
            .SS_WAIT        (1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .arm         (arm),
            .to_slave    (to_slave),
            .from_slave  (from_slave[g]),
            .ready_to_arm(ready[g]),
            .finished    (fin[g]),
            .mosi        (mosi[g]),
            .miso        (miso_s),
            .sck         (sck[g]),
            .ss_L        (ss_l[g])
        );

        assign rcv_all[g] = rcv;

        // Slave reacts half a clk after each master edge, well clear of the next sample.
        always @(negedge clk) begin
            sck_p <= sck[g];
            ss_p  <= ss_l[g];
            if (ss_p && !ss_l[g]) begin
                idx    <= 0;
                rcv    <= '0;
                miso_s <= (CPHA == 0) ? sw[W-1] : 1'b0;
            end else if (!ss_l[g] && (sck[g] != sck_p)) begin
                if ((sck[g] != (CPOL != 0)) == (CPHA == 0)) begin
                    rcv <= {rcv[W-2:0], mosi[g]};
                end else begin
                    if (idx + OFS < 8) miso_s <= sw[7 - idx - OFS];
                    idx <= idx + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic run_xfer(input logic [W-1:0] tx, input logic [W-1:0] s,
                            input int drop_at, input int n_cyc);
        int   first [4];
        int   tog   [4];
        int   fin_c [4];
        logic prev  [4];
        to_slave = tx;
        sw       = s;
        arm      = 1'b1;
        for (int g = 0; g < 4; g++) begin
            prev[g]  = sck[g];
            first[g] = -1;
            tog[g]   = 0;
            fin_c[g] = -1;
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("m%0d ss_low_after_arm", g), 32'(ss_l[g]), 32'd0);
            check($sformatf("m%0d ready_low_after_arm", g), 32'(ready[g]), 32'd0);
            if (g % 2 == 0) check($sformatf("m%0d mosi_msb", g), 32'(mosi[g]), 32'(tx[W-1]));
        end
        for (int c = 1; c <= n_cyc; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) to_slave = ~tx;
            for (int g = 0; g < 4; g++) begin
                if (sck[g] != prev[g]) begin
                    tog[g]++;
                    if (first[g] < 0) first[g] = c;
                    prev[g] = sck[g];
                end
                if (fin[g] && fin_c[g] < 0) fin_c[g] = c;
            end
            if (c == drop_at) arm = 1'b0;
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("m%0d first_edge", g), 32'(first[g]), 32'd3);
            check($sformatf("m%0d edge_count", g), 32'(tog[g]), 32'd16);
            check($sformatf("m%0d finish_cycle", g), 32'(fin_c[g]), 32'd35);
            check($sformatf("m%0d sck_idle", g), 32'(sck[g]), 32'(g / 2));
            check($sformatf("m%0d slave_rx", g), 32'(rcv_all[g]), 32'(tx));
            check($sformatf("m%0d from_slave", g), 32'(from_slave[g]), RD ? 32'(s) : 32'd0);
            if (drop_at == 0) begin
                check($sformatf("m%0d fin_held", g), 32'(fin[g]), 32'd1);
                check($sformatf("m%0d ready_held", g), 32'(ready[g]), 32'd0);
            end else begin
                check($sformatf("m%0d fin_clear", g), 32'(fin[g]), 32'd0);
                check($sformatf("m%0d ready_back", g), 32'(ready[g]), 32'd1);
                check($sformatf("m%0d ss_high_gap", g), 32'(ss_l[g]), 32'd1);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("m%0d %s sck", g, tag), 32'(sck[g]), 32'(g / 2));
            check($sformatf("m%0d %s ss_L", g, tag), 32'(ss_l[g]), 32'd1);
            check($sformatf("m%0d %s mosi", g, tag), 32'(mosi[g]), 32'd0);
            check($sformatf("m%0d %s finished", g, tag), 32'(fin[g]), 32'd0);
            check($sformatf("m%0d %s ready", g, tag), 32'(ready[g]), 32'd1);
            check($sformatf("m%0d %s from_slave", g, tag), 32'(from_slave[g]), 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b0;

        // Abandon a transaction mid-shift, then confirm recovery.
        to_slave = 8'hA5;
        sw       = 8'h3C;
        arm      = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // arm dropped at T0+10; transfer must still complete.
        run_xfer(8'hA5, 8'h3C, 10, 40);

        // arm held for 100 cycles: exactly one transfer, finished stays up.
        run_xfer(8'hA5, 8'h3C, 0, 100);
        arm = 1'b0;
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("m%0d fin_release", g), 32'(fin[g]), 32'd0);
            check($sformatf("m%0d ready_release", g), 32'(ready[g]), 32'd1);
        end

        // Back-to-back words, re-armed as soon as IDLE returns.
        run_xfer(8'hFF, 8'h96, 3, 36);
        run_xfer(8'h00, 8'hFF, 3, 36);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
